// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module      : cpu_pkg
// Description : Shared interrupt-controller types, constants and vector helper.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int          NUM_IRQ    = 4;
  localparam int          ID_W       = 2;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE = 32'd16;
  localparam logic [4:0]  ILR_IDX    = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_SAVE   = 3'd2,
    ST_VECTOR = 3'd3,
    ST_ISR    = 3'd4
  } irq_state_t;

  function automatic logic [31:0] vec_addr(input logic [ID_W-1:0] id);
    return VEC_BASE + ({{(32-ID_W){1'b0}}, id} * VEC_STRIDE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_pending.sv
//------------------------------------------------------------------------------
// Module      : irq_pending
// Description : Rising-edge detect, pending latch, mask register and
//               fixed-priority (line 0 highest) winner select.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module irq_pending
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [NUM_IRQ-1:0] ack,
  output logic               any_eligible,
  output logic [ID_W-1:0]    win_id
);

  logic [NUM_IRQ-1:0] r_irq_hist;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_eligible;

  assign w_rise     = irq_in & ~r_irq_hist;
  assign w_eligible = r_pending & ~r_mask;

  // A new edge wins over an acknowledge landing on the same bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_hist <= '0;
      r_pending  <= '0;
      r_mask     <= '1;
    end else begin
      r_irq_hist <= irq_in;
      r_pending  <= (r_pending & ~ack) | w_rise;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
    end
  end

  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  assign any_eligible = |w_eligible;

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
//------------------------------------------------------------------------------
// Module      : int_ctrl
// Description : Non-nesting interrupt entry sequencer: drain pipeline, save
//               resume PC to ILR, redirect fetch to the handler vector.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module int_ctrl
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               reti,
  input  logic               pipe_empty,
  input  logic [31:0]        pc_fetch,
  output logic               stall_fetch,
  output logic               ilr_we,
  output logic [31:0]        ilr_data,
  output logic               pc_load,
  output logic [31:0]        pc_vec,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr
);

  irq_state_t         r_state;
  irq_state_t         w_state_next;
  logic [31:0]        r_resume_pc;
  logic [ID_W-1:0]    r_cur_id;
  logic               w_any_eligible;
  logic [ID_W-1:0]    w_win_id;

  logic               w_stall;
  logic               w_ilr_we;
  logic [31:0]        w_ilr_data;
  logic               w_pc_load;
  logic [31:0]        w_pc_vec;
  logic [NUM_IRQ-1:0] w_ack;
  logic               w_in_isr;

  irq_pending u_irq_pending (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_in       (irq_in),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .ack          (irq_ack),
    .any_eligible (w_any_eligible),
    .win_id       (w_win_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_resume_pc <= '0;
      r_cur_id    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && w_any_eligible) begin
        r_resume_pc <= pc_fetch;
        r_cur_id    <= w_win_id;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_ilr_we     = 1'b0;
    w_ilr_data   = '0;
    w_pc_load    = 1'b0;
    w_pc_vec     = '0;
    w_ack        = '0;
    w_in_isr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_eligible) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_stall = 1'b1;
        if (pipe_empty) w_state_next = ST_SAVE;
      end
      ST_SAVE: begin
        w_stall      = 1'b1;
        w_ilr_we     = 1'b1;
        w_ilr_data   = r_resume_pc;
        w_state_next = ST_VECTOR;
      end
      ST_VECTOR: begin
        w_stall      = 1'b1;
        w_pc_load    = 1'b1;
        w_pc_vec     = vec_addr(r_cur_id);
        w_ack        = {{(NUM_IRQ-1){1'b0}}, 1'b1} << r_cur_id;
        w_state_next = ST_ISR;
      end
      ST_ISR: begin
        w_in_isr = 1'b1;
        if (reti) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted so an aborted SAVE or
  // VECTOR never leaks a write or a PC redirect.
  assign stall_fetch = w_stall & rst_n;
  assign ilr_we      = w_ilr_we & rst_n;
  assign ilr_data    = rst_n ? w_ilr_data : '0;
  assign pc_load     = w_pc_load & rst_n;
  assign pc_vec      = rst_n ? w_pc_vec : '0;
  assign irq_ack     = rst_n ? w_ack : '0;
  assign in_isr      = w_in_isr & rst_n;

endmodule

`default_nettype wire
